cmd_sequencer: RTL and testbench

Command sequencer sitting between the UART command receiver and the flight datapath (flght_cntrl setpoints, inertial calibration, battery A2D).
- Decodes each received 8-bit command plus 16-bit data.
- Updates setpoint/config registers.
- Sequences multi-step operations (battery conversion, motor spin-up plus inertial calibration).
- Issues exactly one 8-bit response per command back through the UART transmitter.

---
 rtl/cmd_pkg.sv | 30 +++
 rtl/cmd_sequencer_if.sv | 22 ++
 rtl/cmd_timer.sv | 31 +++
 rtl/cmd_sequencer.sv | 176 +++++++++++++++++
 tb/tb_cmd_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the command sequencer.
package cmd_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NAK     = 8'hEE;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_BATT      = 3'd1;
  localparam logic [2:0] S_SPINUP    = 3'd2;
  localparam logic [2:0] S_CAL       = 3'd3;
  localparam logic [2:0] S_RESP_WAIT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_BATT      = S_BATT,
    ST_SPINUP    = S_SPINUP,
    ST_CAL       = S_CAL,
    ST_RESP_WAIT = S_RESP_WAIT
  } state_t;

endpackage

// File: rtl/cmd_sequencer_if.sv
// UART-side command/response handshake between the UART wrapper (master) and the sequencer (slave).
interface cmd_sequencer_if;

  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_sent;

  modport master (
    output cmd_rdy, cmd, data, resp_sent,
    input  clr_cmd_rdy, send_resp, resp
  );

  modport slave (
    input  cmd_rdy, cmd, data, resp_sent,
    output clr_cmd_rdy, send_resp, resp
  );

endinterface

// File: rtl/cmd_timer.sv
// Saturating up-counter: clr_i has priority, counts while en_i, full_o once all-ones.
module cmd_timer #(
  parameter int W = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic full_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign full_o = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !full_o)
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: decodes UART commands, updates setpoints, sequences battery/calibration, one response per command.
// Build macro CMD_WDOG_EN adds a no-command watchdog that zeroes the setpoints.
module cmd_sequencer
  import cmd_pkg::*;
#(
  parameter int SPINUP_W = 26,
  parameter int WD_W     = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  cmd_sequencer_if.slave     uart,
  output logic               strt_cnv,
  input  logic               cnv_cmplt,
  input  logic [7:0]         batt,
  output logic               strt_cal,
  input  logic               cal_done,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst,
  output logic               motors_off
);

  state_t             state_q, state_d;
  logic [7:0]         resp_q, resp_d;
  logic               send_q, send_d;
  logic               cnv_q, cnv_d;
  logic               moff_q, moff_d;
  logic signed [15:0] ptch_q, ptch_d;
  logic signed [15:0] roll_q, roll_d;
  logic signed [15:0] yaw_q, yaw_d;
  logic [8:0]         thrst_q, thrst_d;
  logic               accept;
  logic               spin_full;
  logic               wd_trip;

  // Commands are only taken in IDLE, so a command raised while busy waits in the wrapper.
  assign accept = (state_q == ST_IDLE) && uart.cmd_rdy;

  cmd_timer #(.W(SPINUP_W)) u_spinup (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept && (uart.cmd == CALIBRATE)),
    .en_i   (state_q == ST_SPINUP),
    .full_o (spin_full)
  );

`ifdef CMD_WDOG_EN
  logic wd_full;

  cmd_timer #(.W(WD_W)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   ((state_q != ST_SPINUP) && (state_q != ST_CAL)),
    .full_o (wd_full)
  );

  assign wd_trip = wd_full && (state_q == ST_IDLE);
`else
  assign wd_trip = (WD_W < 0);
`endif

  always_comb begin
    state_d  = state_q;
    resp_d   = resp_q;
    send_d   = 1'b0;
    cnv_d    = 1'b0;
    moff_d   = moff_q;
    ptch_d   = ptch_q;
    roll_d   = roll_q;
    yaw_d    = yaw_q;
    thrst_d  = thrst_q;

    // Watchdog landing is silent; a command accepted the same cycle overrides it below.
    if (wd_trip) begin
      ptch_d  = '0;
      roll_d  = '0;
      yaw_d   = '0;
      thrst_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (uart.cmd_rdy) begin
          send_d  = 1'b1;
          resp_d  = POS_ACK;
          state_d = ST_RESP_WAIT;
          case (uart.cmd)
            REQ_BATT: begin
              send_d  = 1'b0;
              cnv_d   = 1'b1;
              state_d = ST_BATT;
            end
            SET_PTCH:  ptch_d  = uart.data;
            SET_ROLL:  roll_d  = uart.data;
            SET_YAW:   yaw_d   = uart.data;
            SET_THRST: thrst_d = uart.data[8:0];
            CALIBRATE: begin
              send_d  = 1'b0;
              moff_d  = 1'b0;
              state_d = ST_SPINUP;
            end
            EMER_LAND: begin
              ptch_d  = '0;
              roll_d  = '0;
              yaw_d   = '0;
              thrst_d = '0;
            end
            MTRS_OFF: moff_d = 1'b1;
            default:  resp_d = NAK;
          endcase
        end
      end
      ST_BATT: begin
        if (cnv_cmplt) begin
          resp_d  = batt;
          send_d  = 1'b1;
          state_d = ST_RESP_WAIT;
        end
      end
      ST_SPINUP: begin
        if (spin_full)
          state_d = ST_CAL;
      end
      ST_CAL: begin
        if (cal_done) begin
          resp_d  = POS_ACK;
          send_d  = 1'b1;
          state_d = ST_RESP_WAIT;
        end
      end
      ST_RESP_WAIT: begin
        if (uart.resp_sent)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      resp_q  <= '0;
      send_q  <= 1'b0;
      cnv_q   <= 1'b0;
      moff_q  <= 1'b1;
      ptch_q  <= '0;
      roll_q  <= '0;
      yaw_q   <= '0;
      thrst_q <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      send_q  <= send_d;
      cnv_q   <= cnv_d;
      moff_q  <= moff_d;
      ptch_q  <= ptch_d;
      roll_q  <= roll_d;
      yaw_q   <= yaw_d;
      thrst_q <= thrst_d;
    end
  end

  assign uart.clr_cmd_rdy = accept;
  assign uart.send_resp   = send_q;
  assign uart.resp        = resp_q;
  assign strt_cnv         = cnv_q;
  assign strt_cal         = (state_q == ST_SPINUP) && spin_full;
  assign d_ptch           = ptch_q;
  assign d_roll           = roll_q;
  assign d_yaw            = yaw_q;
  assign thrst            = thrst_q;
  assign motors_off       = moff_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: vector table, directed multi-cycle sequences, randomized commands vs a reference model.
module tb_cmd_sequencer;
  import cmd_pkg::*;

  localparam int SPW = 9;
  localparam int WDW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_sequencer_if uart ();
  logic        strt_cnv, strt_cal, motors_off;
  logic        cnv_cmplt = 1'b0;
  logic        cal_done  = 1'b0;
  logic [7:0]  batt      = 8'h00;
  logic [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;

  cmd_sequencer #(.SPINUP_W(SPW), .WD_W(WDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart       (uart.slave),
    .strt_cnv   (strt_cnv),
    .cnv_cmplt  (cnv_cmplt),
    .batt       (batt),
    .strt_cal   (strt_cal),
    .cal_done   (cal_done),
    .d_ptch     (d_ptch),
    .d_roll     (d_roll),
    .d_yaw      (d_yaw),
    .thrst      (thrst),
    .motors_off (motors_off)
  );

  int checks = 0;
  int errors = 0;
  int n_cnv = 0, n_cal = 0, n_clr = 0, n_resp = 0;
  bit outstanding = 1'b0;
  logic [7:0] held = 8'h00;

  // Reference model state: what the setpoints must be after each command.
  logic [15:0] m_ptch = '0, m_roll = '0, m_yaw = '0;
  logic [8:0]  m_thrst = '0;
  logic        m_moff = 1'b1;

  typedef struct {
    logic [7:0]  c;
    logic [15:0] d;
    logic [7:0]  b;
    logic [7:0]  resp;
    logic [15:0] ptch, roll, yaw;
    logic [8:0]  thrst;
    logic        moff;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse counters plus one-response-outstanding and resp-hold checks.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      outstanding = 1'b0;
    end else begin
      if (strt_cnv) n_cnv++;
      if (strt_cal) n_cal++;
      if (uart.clr_cmd_rdy) n_clr++;
      if (uart.send_resp) begin
        n_resp++;
        chk("resp_overlap", 32'(outstanding), 32'd0);
        outstanding = 1'b1;
        held = uart.resp;
      end else if (outstanding) begin
        chk("resp_hold", 32'(uart.resp), 32'(held));
      end
      if (uart.resp_sent) outstanding = 1'b0;
    end
  end

  function automatic vec_t mk(input logic [7:0] c, input logic [15:0] d, input logic [7:0] b,
                              input logic [7:0] r, input logic [15:0] p, input logic [15:0] ro,
                              input logic [15:0] y, input logic [8:0] t, input logic mo);
    vec_t v;
    v.c = c; v.d = d; v.b = b; v.resp = r;
    v.ptch = p; v.roll = ro; v.yaw = y; v.thrst = t; v.moff = mo;
    return v;
  endfunction

  function automatic logic [7:0] model_step(input logic [7:0] c, input logic [15:0] d, input logic [7:0] b);
    case (c)
      8'h01: return b;
      8'h02: begin m_ptch = d; return 8'hA5; end
      8'h03: begin m_roll = d; return 8'hA5; end
      8'h04: begin m_yaw = d; return 8'hA5; end
      8'h05: begin m_thrst = d[8:0]; return 8'hA5; end
      8'h07: begin m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; return 8'hA5; end
      8'h08: begin m_moff = 1'b1; return 8'hA5; end
      default: return 8'hEE;
    endcase
  endfunction

  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    uart.cmd_rdy = 1'b1;
    uart.cmd     = c;
    uart.data    = d;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (uart.clr_cmd_rdy) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("cmd_accepted", 32'(got), 32'd1);
    @(negedge clk);
    uart.cmd_rdy = 1'b0;
  endtask

  task automatic batt_reply(input logic [7:0] b);
    for (int n = 0; n < 16; n++) begin
      if (strt_cnv) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    batt = b;
    cnv_cmplt = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b0;
  endtask

  task automatic get_resp(output logic [7:0] r, output bit ok);
    ok = 1'b0;
    r  = 8'h00;
    for (int n = 0; n < 2000; n++) begin
      if (uart.send_resp) begin
        ok = 1'b1;
        r  = uart.resp;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    uart.resp_sent = 1'b1;
    @(negedge clk);
    uart.resp_sent = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [7:0] c, input logic [15:0] d, input logic [7:0] b,
                     input logic [7:0] e_resp, input logic [15:0] e_ptch, input logic [15:0] e_roll,
                     input logic [15:0] e_yaw, input logic [8:0] e_thrst, input logic e_moff);
    int cnv0;
    logic [7:0] r;
    bit ok;
    cnv0 = n_cnv;
    send_cmd(c, d);
    chk({tag, "_ptch"},  32'(d_ptch),     32'(e_ptch));
    chk({tag, "_roll"},  32'(d_roll),     32'(e_roll));
    chk({tag, "_yaw"},   32'(d_yaw),      32'(e_yaw));
    chk({tag, "_thrst"}, 32'(thrst),      32'(e_thrst));
    chk({tag, "_moff"},  32'(motors_off), 32'(e_moff));
    if (c == REQ_BATT) batt_reply(b);
    get_resp(r, ok);
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    chk({tag, "_resp"}, 32'(r), 32'(e_resp));
    chk({tag, "_cnv"}, 32'(n_cnv - cnv0), (c == REQ_BATT) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, cal0, resp0, cnv0, clr0, k;
    logic [7:0] r, c, b, er;
    logic [15:0] d;
    bit ok;

    uart.cmd_rdy   = 1'b0;
    uart.cmd       = 8'h00;
    uart.data      = 16'h0000;
    uart.resp_sent = 1'b0;

    tbl[0]  = mk(8'h01, 16'h0000, 8'hC0, 8'hC0, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b0);
    tbl[1]  = mk(8'h01, 16'h0000, 8'hBF, 8'hBF, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b0);
    tbl[2]  = mk(8'h01, 16'h0000, 8'hBE, 8'hBE, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b0);
    tbl[3]  = mk(8'h02, 16'hFF80, 8'h00, 8'hA5, 16'hFF80, 16'h0000, 16'h0000, 9'h000, 1'b0);
    tbl[4]  = mk(8'h03, 16'h1234, 8'h00, 8'hA5, 16'hFF80, 16'h1234, 16'h0000, 9'h000, 1'b0);
    tbl[5]  = mk(8'h04, 16'h8001, 8'h00, 8'hA5, 16'hFF80, 16'h1234, 16'h8001, 9'h000, 1'b0);
    tbl[6]  = mk(8'h05, 16'h01F4, 8'h00, 8'hA5, 16'hFF80, 16'h1234, 16'h8001, 9'h1F4, 1'b0);
    tbl[7]  = mk(8'h3C, 16'hFFFF, 8'h00, 8'hEE, 16'hFF80, 16'h1234, 16'h8001, 9'h1F4, 1'b0);
    tbl[8]  = mk(8'h05, 16'hFF00, 8'h00, 8'hA5, 16'hFF80, 16'h1234, 16'h8001, 9'h100, 1'b0);
    tbl[9]  = mk(8'h03, 16'h0040, 8'h00, 8'hA5, 16'hFF80, 16'h0040, 16'h8001, 9'h100, 1'b0);
    tbl[10] = mk(8'h07, 16'hABCD, 8'h00, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b0);
    tbl[11] = mk(8'h08, 16'h0000, 8'h00, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1);
    tbl[12] = mk(8'h00, 16'h1111, 8'h00, 8'hEE, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1);
    tbl[13] = mk(8'h09, 16'h2222, 8'h00, 8'hEE, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_moff",  32'(motors_off),       32'd1);
    chk("rst_thrst", 32'(thrst),            32'd0);
    chk("rst_ptch",  32'(d_ptch),           32'd0);
    chk("rst_send",  32'(uart.send_resp),   32'd0);
    chk("rst_cnv",   32'(strt_cnv),         32'd0);
    chk("rst_cal",   32'(strt_cal),         32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Calibration: motors_off drops at accept, strt_cal 511 cycles later
    cal0 = n_cal;
    send_cmd(CALIBRATE, 16'h0000);
    chk("cal_moff_drop", 32'(motors_off), 32'd0);
    cnt = 0;
    while (!strt_cal && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("cal_spinup_cycles", 32'(cnt), 32'd511);
    resp0 = n_resp;
    repeat (100) @(negedge clk);
    chk("cal_no_early_resp", 32'(n_resp - resp0), 32'd0);
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    get_resp(r, ok);
    chk("cal_seen", 32'(ok), 32'd1);
    chk("cal_resp", 32'(r), 32'hA5);
    chk("cal_pulses", 32'(n_cal - cal0), 32'd1);

    // Vector table
    for (int i = 0; i < 14; i++)
      txn($sformatf("vec%0d", i), tbl[i].c, tbl[i].d, tbl[i].b, tbl[i].resp,
          tbl[i].ptch, tbl[i].roll, tbl[i].yaw, tbl[i].thrst, tbl[i].moff);
    m_ptch = '0; m_roll = '0; m_yaw = '0; m_thrst = '0; m_moff = 1'b1;

    // Command raised while busy is accepted only once, after resp_sent
    clr0 = n_clr;
    send_cmd(REQ_BATT, 16'h0000);
    uart.cmd_rdy = 1'b1;
    uart.cmd     = SET_PTCH;
    uart.data    = 16'h5555;
    repeat (4) @(negedge clk);
    batt = 8'h77;
    cnv_cmplt = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    chk("busy_send", 32'(uart.send_resp), 32'd1);
    chk("busy_batt_resp", 32'(uart.resp), 32'h77);
    repeat (2) @(negedge clk);
    uart.resp_sent = 1'b1;
    #1;
    chk("busy_clr_with_sent", 32'(uart.clr_cmd_rdy), 32'd0);
    @(negedge clk);
    uart.resp_sent = 1'b0;
    #1;
    chk("busy_clr_after_sent", 32'(uart.clr_cmd_rdy), 32'd1);
    @(negedge clk);
    uart.cmd_rdy = 1'b0;
    chk("busy_ptch", 32'(d_ptch), 32'h5555);
    get_resp(r, ok);
    chk("busy_resp", 32'(r), 32'hA5);
    chk("busy_clr_count", 32'(n_clr - clr0), 32'd2);
    m_ptch = 16'h5555;

    // cnv_cmplt / cal_done while IDLE are ignored
    resp0 = n_resp;
    clr0  = n_clr;
    @(negedge clk);
    batt = 8'h55;
    cnv_cmplt = 1'b1;
    cal_done  = 1'b1;
    repeat (2) @(negedge clk);
    cnv_cmplt = 1'b0;
    cal_done  = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_ignore_resp", 32'(n_resp - resp0), 32'd0);
    chk("idle_ignore_clr",  32'(n_clr - clr0),   32'd0);

    // Randomized commands against the reference model
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 7);
      case (k)
        0:       c = REQ_BATT;
        5:       c = EMER_LAND;
        6:       c = MTRS_OFF;
        7:       c = 8'($urandom_range(9, 255));
        default: c = 8'(k + 1);
      endcase
      d  = 16'($urandom);
      b  = 8'($urandom);
      er = model_step(c, d, b);
      txn($sformatf("rnd%0d", i), c, d, b, er, m_ptch, m_roll, m_yaw, m_thrst, m_moff);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Asynchronous reset while in BATT: reset values, no response afterwards
    resp0 = n_resp;
    send_cmd(REQ_BATT, 16'h0000);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_moff",  32'(motors_off),     32'd1);
    chk("abort_thrst", 32'(thrst),          32'd0);
    chk("abort_ptch",  32'(d_ptch),         32'd0);
    chk("abort_roll",  32'(d_roll),         32'd0);
    chk("abort_send",  32'(uart.send_resp), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    batt = 8'h33;
    cnv_cmplt = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_resp", 32'(n_resp - resp0), 32'd0);
    m_ptch = '0; m_roll = '0; m_yaw = '0; m_thrst = '0; m_moff = 1'b1;
    er = model_step(SET_YAW, 16'h0BAD, 8'h00);
    txn("post_rst", SET_YAW, 16'h0BAD, 8'h00, er, m_ptch, m_roll, m_yaw, m_thrst, m_moff);

`ifdef CMD_WDOG_EN
    // Watchdog: setpoints cleared silently after 2^WD_W-1 cycles without a command
    er = model_step(SET_THRST, 16'h0080, 8'h00);
    txn("wd_set", SET_THRST, 16'h0080, 8'h00, er, m_ptch, m_roll, m_yaw, m_thrst, m_moff);
    resp0 = n_resp;
    repeat (500) @(negedge clk);
    chk("wd_hold", 32'(thrst), 32'h080);
    cnt = 0;
    while (thrst != 9'h000 && cnt < 1500) begin
      @(negedge clk);
      cnt++;
    end
    chk("wd_thrst", 32'(thrst), 32'd0);
    chk("wd_yaw", 32'(d_yaw), 32'd0);
    chk("wd_no_resp", 32'(n_resp - resp0), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
